// File: rtl/wb_writer.sv
// Writeback buffer: circular FIFO of {rd, data} results draining one per cycle into the register file.
// Optional store-to-read bypass of pending entries is enabled by defining WB_WRITER_BYPASS_EN.
module wb_writer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stallM,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [63:0]              in_data,
    output logic                     W_en,
    output logic [4:0]               Rd,
    output logic [63:0]              Wr_data,
    input  logic [4:0]               Rs1,
    input  logic [4:0]               Rs2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [63:0]              fwd_data1,
    output logic [63:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    rd_mem_q   [DEPTH];
    logic [4:0]    rd_mem_d   [DEPTH];
    logic [63:0]   data_mem_q [DEPTH];
    logic [63:0]   data_mem_d [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // in_ready depends only on registered occupancy, never on stallM
    assign in_ready = (count_q < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_rd != 5'd0);
    assign pop      = W_en;

    assign W_en    = (count_q != '0) && !stallM;
    assign Rd      = (count_q != '0) ? rd_mem_q[head_q]   : '0;
    assign Wr_data = (count_q != '0) ? data_mem_q[head_q] : '0;
    assign count   = count_q;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            rd_mem_d[tail_q]   = in_rd;
            data_mem_d[tail_q] = in_data;
            tail_d             = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: every read of it is qualified by count_q
    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

`ifdef WB_WRITER_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        idx       = '0;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((Rs1 != 5'd0) && (rd_mem_q[idx] == Rs1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_mem_q[idx];
                end
                if ((Rs2 != 5'd0) && (rd_mem_q[idx] == Rs2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_mem_q[idx];
                end
            end
        end
    end
`else
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule
